// File: rtl/periph_bus_master_if.sv
// Host-side command/response handshake bundle for periph_bus_master.
// master: seen by the bus master; slave: seen by the host driving commands.
interface periph_bus_master_if #(
    parameter int N = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/periph_bus_master.sv
// Peripheral bus master: turns host commands into DIR/OUT/IN strobes on a shared bus.
// Define PERIPH_BUS_TURNAROUND_EN to add one idle bus cycle after every read response.
module periph_bus_master #(
    parameter int N = 4
) (
    input  logic                clock,
    input  logic                reset,
    periph_bus_master_if.master host,
    inout  wire  [N-1:0]        data_bus,
    output logic                LOAD_DIR,
    output logic                LOAD_OUT,
    output logic                READ_IN,
    output logic                err_op,
    output logic [7:0]          op_count
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP,
        TURN
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [1:0]   op_q;
    logic [N-1:0] data_q;
    logic [N-1:0] rsp_q;
    logic         err_q;
    logic [7:0]   count_q;
    logic         ready;
    logic         rsp_v;
    logic         bus_drive;
    logic         accept;
    logic         strobe;

    assign accept   = ready & host.cmd_valid;
    assign strobe   = LOAD_DIR | LOAD_OUT | READ_IN;
    assign data_bus = bus_drive ? data_q : {N{1'bz}};

    assign host.cmd_ready = ready;
    assign host.rsp_valid = rsp_v;
    assign host.rsp_data  = rsp_q;
    assign err_op         = err_q;
    assign op_count       = count_q;

    // State register; reset wins over any in-flight transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command capture, read capture, error flag and strobe counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q    <= 2'b00;
            data_q  <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            if (accept) begin
                op_q   <= host.cmd_op;
                data_q <= host.cmd_data;
                if (host.cmd_op == 2'b11) begin
                    err_q <= 1'b1;
                end
            end
            if (state == READ) begin
                rsp_q <= data_bus;
            end
            if (strobe) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    // Next state and per-state outputs; a reserved op spends its one
    // busy cycle in WRITE with neither strobe nor bus drive.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        rsp_v      = 1'b0;
        LOAD_DIR   = 1'b0;
        LOAD_OUT   = 1'b0;
        READ_IN    = 1'b0;
        bus_drive  = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (host.cmd_valid) begin
                    state_next = (host.cmd_op == 2'b10) ? READ : WRITE;
                end
            end
            WRITE: begin
                LOAD_DIR   = (op_q == 2'b00);
                LOAD_OUT   = (op_q == 2'b01);
                bus_drive  = ~op_q[1];
                state_next = IDLE;
            end
            READ: begin
                READ_IN    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp_v = 1'b1;
                if (host.rsp_ready) begin
`ifdef PERIPH_BUS_TURNAROUND_EN
                    state_next = TURN;
`else
                    state_next = IDLE;
`endif
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_periph_bus_master.sv
// Self-checking bench for periph_bus_master: directed vector table,
// op_count wrap sequence, and random traffic against a slot-queue model.
module tb_periph_bus_master;
    localparam int N = 4;

    logic       clock;
    logic       reset;
    logic       pe;
    logic [3:0] pv;
    wire  [3:0] data_bus;
    logic       LOAD_DIR;
    logic       LOAD_OUT;
    logic       READ_IN;
    logic       err_op;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    periph_bus_master_if #(.N(N)) bus_if ();

    periph_bus_master #(.N(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .host     (bus_if),
        .data_bus (data_bus),
        .LOAD_DIR (LOAD_DIR),
        .LOAD_OUT (LOAD_OUT),
        .READ_IN  (READ_IN),
        .err_op   (err_op),
        .op_count (op_count)
    );

    assign data_bus = pe ? pv : 4'bzzzz;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         rst;
        bit         cv;
        logic [1:0] op;
        logic [3:0] cd;
        bit         rr;
        bit         pe;
        logic [3:0] pv;
        bit         e_rdy;
        bit         e_rv;
        bit         e_dir;
        bit         e_out;
        bit         e_in;
        bit         e_err;
        logic [7:0] e_cnt;
        logic [3:0] e_rsp;
        logic [3:0] e_bus;
    } vec_t;

    typedef struct {
        bit         dir;
        bit         out;
        bit         rin;
        bit         drv;
        bit         rv;
        bit         hold;
        logic [3:0] bus;
    } slot_t;

    vec_t  tbl[$];
    slot_t sched[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input bit rdy, input bit rv, input bit dir,
                              input bit out, input bit rin, input bit err,
                              input logic [7:0] cnt, input logic [3:0] rsp,
                              input logic [3:0] bus);
        check("cmd_ready", 32'(bus_if.cmd_ready), 32'(rdy));
        check("rsp_valid", 32'(bus_if.rsp_valid), 32'(rv));
        check("LOAD_DIR", 32'(LOAD_DIR), 32'(dir));
        check("LOAD_OUT", 32'(LOAD_OUT), 32'(out));
        check("READ_IN", 32'(READ_IN), 32'(rin));
        check("err_op", 32'(err_op), 32'(err));
        check("op_count", 32'(op_count), 32'(cnt));
        check("rsp_data", 32'(bus_if.rsp_data), 32'(rsp));
        check("data_bus", 32'(data_bus), 32'(bus));
    endtask

    task automatic drive(input bit r, input bit cv, input logic [1:0] op,
                         input logic [3:0] cd, input bit rr);
        reset             = r;
        bus_if.cmd_valid  = cv;
        bus_if.cmd_op     = op;
        bus_if.cmd_data   = cd;
        bus_if.rsp_ready  = rr;
    endtask

    task automatic accept_cmd(input logic [1:0] op, input logic [3:0] cd,
                              inout bit m_err);
        slot_t s;
        s = '{default: '0};
        case (op)
            2'b00: begin
                s.dir = 1'b1; s.drv = 1'b1; s.bus = cd;
                sched.push_back(s);
            end
            2'b01: begin
                s.out = 1'b1; s.drv = 1'b1; s.bus = cd;
                sched.push_back(s);
            end
            2'b10: begin
                s.rin = 1'b1;
                sched.push_back(s);
                s = '{default: '0};
                s.rv = 1'b1; s.hold = 1'b1;
                sched.push_back(s);
`ifdef PERIPH_BUS_TURNAROUND_EN
                s = '{default: '0};
                sched.push_back(s);
`endif
            end
            default: begin
                sched.push_back(s);
                m_err = 1'b1;
            end
        endcase
    endtask

    initial begin
        slot_t      cur;
        logic [3:0] m_rsp;
        bit         m_err;
        logic [7:0] m_cnt;

        drive(1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
        pe = 1'b1;
        pv = 4'h0;
        repeat (2) @(negedge clock);

        // rst cv op cd rr pe pv | rdy rv dir out in err cnt rsp bus
        tbl.push_back(vec_t'{1,1,2'b00,4'hA,0,1,4'h5, 1,0,0,0,0,0,8'd0,4'h0,4'h5});
        tbl.push_back(vec_t'{0,1,2'b00,4'hA,0,1,4'h3, 1,0,0,0,0,0,8'd0,4'h0,4'h3});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,0,0,4'h0, 0,0,1,0,0,0,8'd0,4'h0,4'hA});
        tbl.push_back(vec_t'{0,1,2'b01,4'hF,0,1,4'h6, 1,0,0,0,0,0,8'd1,4'h0,4'h6});
        tbl.push_back(vec_t'{0,1,2'b10,4'h0,0,0,4'h0, 0,0,0,1,0,0,8'd1,4'h0,4'hF});
        tbl.push_back(vec_t'{0,1,2'b10,4'h0,0,1,4'h6, 1,0,0,0,0,0,8'd2,4'h0,4'h6});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,0,1,4'h6, 0,0,0,0,1,0,8'd2,4'h0,4'h6});
        tbl.push_back(vec_t'{0,1,2'b00,4'h9,0,1,4'h2, 0,1,0,0,0,0,8'd3,4'h6,4'h2});
        tbl.push_back(vec_t'{0,1,2'b00,4'h9,0,1,4'h2, 0,1,0,0,0,0,8'd3,4'h6,4'h2});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,0,1,4'h2, 0,1,0,0,0,0,8'd3,4'h6,4'h2});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,1,1,4'h2, 0,1,0,0,0,0,8'd3,4'h6,4'h2});
`ifdef PERIPH_BUS_TURNAROUND_EN
        tbl.push_back(vec_t'{0,1,2'b00,4'h0,1,1,4'h1, 0,0,0,0,0,0,8'd3,4'h6,4'h1});
`endif
        tbl.push_back(vec_t'{0,1,2'b11,4'h7,0,1,4'h4, 1,0,0,0,0,0,8'd3,4'h6,4'h4});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,0,1,4'h8, 0,0,0,0,0,1,8'd3,4'h6,4'h8});
        tbl.push_back(vec_t'{0,1,2'b10,4'h0,0,1,4'hC, 1,0,0,0,0,1,8'd3,4'h6,4'hC});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,1,1,4'hD, 0,0,0,0,1,1,8'd3,4'h6,4'hD});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,1,1,4'h1, 0,1,0,0,0,1,8'd4,4'hD,4'h1});
`ifdef PERIPH_BUS_TURNAROUND_EN
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,0,1,4'h1, 0,0,0,0,0,1,8'd4,4'hD,4'h1});
`endif
        tbl.push_back(vec_t'{0,1,2'b10,4'h0,0,1,4'h2, 1,0,0,0,0,1,8'd4,4'hD,4'h2});
        tbl.push_back(vec_t'{1,0,2'b00,4'h0,0,1,4'h3, 0,0,0,0,1,1,8'd4,4'hD,4'h3});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,0,1,4'h4, 1,0,0,0,0,0,8'd0,4'h0,4'h4});
        tbl.push_back(vec_t'{0,0,2'b00,4'h0,0,1,4'h9, 1,0,0,0,0,0,8'd0,4'h0,4'h9});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].cv, tbl[i].op, tbl[i].cd, tbl[i].rr);
            pe = tbl[i].pe;
            pv = tbl[i].pv;
            #1;
            check_outs(tbl[i].e_rdy, tbl[i].e_rv, tbl[i].e_dir, tbl[i].e_out,
                       tbl[i].e_in, tbl[i].e_err, tbl[i].e_cnt, tbl[i].e_rsp,
                       tbl[i].e_bus);
            @(negedge clock);
        end

        // 256 back-to-back writes: counter must wrap to 0.
        drive(1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
        pe = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus_if.cmd_valid = 1'b1;
            bus_if.cmd_op    = 2'($urandom_range(0, 1));
            bus_if.cmd_data  = i[3:0];
            #1;
            if (i == 255) check("cnt_255", 32'(op_count), 32'd255);
            @(negedge clock);
            bus_if.cmd_valid = 1'b0;
            #1;
            check("wr_strobe", 32'(LOAD_DIR | LOAD_OUT), 32'd1);
            @(negedge clock);
        end
        #1;
        check("cnt_wrap", 32'(op_count), 32'd0);
        check("wrap_ready", 32'(bus_if.cmd_ready), 32'd1);

        // Random traffic against the slot-queue model.
        drive(1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
        pe    = 1'b1;
        m_rsp = 4'h0;
        m_err = 1'b0;
        m_cnt = 8'd0;
        sched.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            drive($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'($urandom),
                  1'($urandom_range(0, 1)));
            cur = '{default: '0};
            if (sched.size() != 0) cur = sched[0];
            pv = 4'($urandom);
            pe = ~cur.drv;
            #1;
            check_outs(sched.size() == 0, cur.rv, cur.dir, cur.out, cur.rin,
                       m_err, m_cnt, m_rsp, cur.drv ? cur.bus : pv);
            @(posedge clock);
            if (reset) begin
                sched.delete();
                m_rsp = 4'h0;
                m_err = 1'b0;
                m_cnt = 8'd0;
            end else if (sched.size() == 0) begin
                if (bus_if.cmd_valid) accept_cmd(bus_if.cmd_op, bus_if.cmd_data, m_err);
            end else begin
                if (cur.dir | cur.out | cur.rin) m_cnt = m_cnt + 8'd1;
                if (cur.rin) m_rsp = pv;
                if (!(cur.hold && !bus_if.rsp_ready)) void'(sched.pop_front());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/periph_bus_master.md
PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 Parameter N, default 4: width of the peripheral data bus and the command/response data.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered by host.
REQ-005 cmd_ready  output  1  master can accept a command this cycle.
REQ-006 cmd_op  input  2  00 write DIR, 01 write OUT, 10 read IN, 11 reserved.
REQ-007 cmd_data  input  N  write data for ops 00 and 01; ignored otherwise.
REQ-008 rsp_valid  output  1  read data available.
REQ-009 rsp_ready  input  1  host accepts the response.
REQ-010 rsp_data  output  N  captured read data.
REQ-011 data_bus  inout  N  shared peripheral data bus; high-Z unless the master is driving.
REQ-012 LOAD_DIR, LOAD_OUT, READ_IN  output  1 each  peripheral strobes.
REQ-013 err_op  output  1  sticky flag for a reserved opcode.
REQ-014 op_count  output  8  count of issued strobes.

Function
REQ-015 A command is accepted on an edge where cmd_valid and cmd_ready are both 1; cmd_op and cmd_data are registered at that edge.
REQ-016 The FSM states are IDLE, WRITE, READ, RESP and TURN; cmd_ready is 1 only in IDLE.
REQ-017 An accepted op 00/01 at edge k enters WRITE for cycle k+1; during that cycle data_bus carries the registered data and exactly one of LOAD_DIR/LOAD_OUT is 1, then the FSM returns to IDLE at edge k+2.
REQ-018 An accepted op 10 at edge k enters READ for cycle k+1 with READ_IN=1 and data_bus high-Z; edge k+2 registers data_bus into rsp_data and enters RESP.
REQ-019 In RESP, rsp_valid is 1 and rsp_data holds stable until an edge with rsp_ready=1, after which the FSM goes to TURN or IDLE per REQ-031/032.
REQ-020 rsp_ready may already be 1 when RESP is entered; RESP then lasts exactly one cycle.
REQ-021 An accepted op 11 produces no strobe, leaves the bus high-Z, sets err_op, and returns to IDLE after one cycle.
REQ-022 Strobes are mutually exclusive, each is exactly one cycle wide, and all are 0 in every state except WRITE/READ.
REQ-023 data_bus is driven only in WRITE; it is high-Z in all other states.
REQ-024 op_count increments by 1 on each strobe cycle and wraps from 255 to 0.
REQ-025 err_op stays set until reset.
REQ-026 cmd_valid is ignored while cmd_ready=0; rsp_ready is ignored while rsp_valid=0.

Reset
REQ-027 At an edge with reset=1, the FSM enters IDLE regardless of current state, including mid-WRITE, mid-READ, RESP and TURN.
REQ-028 After reset: cmd_ready=1, rsp_valid=0, rsp_data=0, all strobes 0, data_bus high-Z, err_op=0, op_count=0.
REQ-029 A command presented during the reset cycle is not accepted.
REQ-030 An in-flight read response is discarded by reset.

Configuration
REQ-031 With PERIPH_BUS_TURNAROUND_EN defined, every RESP exit passes through one TURN cycle (cmd_ready=0, bus high-Z, no strobes) before IDLE, giving a guaranteed idle bus cycle after the peripheral drives it.
REQ-032 Without PERIPH_BUS_TURNAROUND_EN, TURN is unreachable and RESP exits directly to IDLE.

Verification
REQ-033 Reset, then op 00 with data 4'b1010 accepted at edge k -> LOAD_DIR=1 and data_bus=1010 in cycle k+1 only; cmd_ready=1 again in cycle k+2; op_count=1.
REQ-034 Op 10 with peripheral driving 4'b0110 and rsp_ready held 0 for 3 cycles -> rsp_data=0110 and rsp_valid=1 from cycle k+2 through the handshake; cmd_ready=0 throughout; data_bus never driven by the master.
REQ-035 Back-to-back ops 01 (4'b1111) then 10 with cmd_valid held high -> strobes LOAD_OUT then READ_IN, never overlapping; with PERIPH_BUS_TURNAROUND_EN, one extra cycle with cmd_ready=0 after the response handshake.
REQ-036 Op 11 -> no strobe, err_op=1, op_count unchanged; err_op persists until reset.
REQ-037 reset asserted during the READ cycle -> next cycle shows IDLE outputs per REQ-028, with no rsp_valid pulse.
REQ-038 256 consecutive writes -> op_count wraps to 0.
